// File: rtl/traffic_phase_monitor_if.sv
// Signal-head bus between the traffic controller (master) and the phase
// monitor (slave), plus the monitor's status outputs.
// This is a sampled level bus with no flow control: there is no valid/ready
// pair. The monitor registers the four light codes on every clk edge, and its
// status outputs are plain registered levels apart from the one-cycle
// phase_change pulse.
interface traffic_phase_monitor_if;
  logic [1:0] north;
  logic [1:0] east;
  logic [1:0] south;
  logic [1:0] west;
  logic       clear;
  logic [3:0] phase;
  logic       phase_change;
  logic [4:0] dwell_sec;
  logic [3:0] fault;
  logic       fault_any;
  logic [7:0] cycles;

  modport master (
    output north, east, south, west, clear,
    input  phase, phase_change, dwell_sec, fault, fault_any, cycles
  );

  modport slave (
    input  north, east, south, west, clear,
    output phase, phase_change, dwell_sec, fault, fault_any, cycles
  );
endinterface

// File: rtl/traffic_phase_monitor.sv
// traffic_phase_monitor: receive-side checker for the four-way signal heads.
// Decodes registered light codes into a controller phase, then flags head
// conflicts, illegal codes, out-of-order phases and bad dwell times.
// All fault flags are sticky. Completed S7->S0 cycles are counted.
// Optional feature macro: PHASE_MON_DWELL_CHECK_EN. When it is defined, the
// prescaler, the dwell counter and the dwell fault are built. When it is not
// defined, dwell_sec and fault[3] are tied to 0.
module traffic_phase_monitor #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int GREEN_SEC  = 5,
  parameter int YELLOW_SEC = 1,
  parameter int TOL_SEC    = 0
) (
  input logic                    clk,
  input logic                    reset,
  traffic_phase_monitor_if.slave bus
);

  typedef enum logic [3:0] {
    PH_RST     = 4'h0,
    PH_S0      = 4'h1,
    PH_S1      = 4'h2,
    PH_S2      = 4'h3,
    PH_S3      = 4'h4,
    PH_S4      = 4'h5,
    PH_S5      = 4'h6,
    PH_S6      = 4'h7,
    PH_S7      = 4'h8,
    PH_ALLRED  = 4'h9,
    PH_NONE    = 4'hE,
    PH_INVALID = 4'hF
  } phase_t;

  // Packed codes, ordered {north, east, south, west}.
  logic [7:0] in_q;
  phase_t     phase_q, phase_d, dec;
  logic       change;
  logic       change_q;
  logic [3:0] fault_q;
  logic [7:0] cycles_q;
  logic [3:0] greens, yellows;
  logic       conflict, illegal, seq_err, cyc_evt, dwell_err;

  // True when the step from f to t is a legal controller step.
  function automatic logic seq_ok(input logic [3:0] f, input logic [3:0] t);
    logic ok;
    ok = 1'b0;
    case (f)
      PH_NONE:   ok = 1'b1;
      PH_RST:    ok = (t == PH_S0);
      PH_S7:     ok = (t == PH_S0);
      PH_ALLRED: ok = (t == PH_RST);
      PH_S0, PH_S1, PH_S2, PH_S3, PH_S4, PH_S5, PH_S6:
                 ok = (t == f + 4'd1);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Input stage. It keeps sampling during reset, so the first decode after
  // reset sees the live bus and not a stale value.
  always_ff @(posedge clk) begin
    in_q <= {bus.north, bus.east, bus.south, bus.west};
  end

  // Decode the registered codes and classify head conflicts and illegal codes.
  always_comb begin
    greens  = '0;
    yellows = '0;
    illegal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      greens[i]  = (in_q[2*i +: 2] == 2'b10);
      yellows[i] = (in_q[2*i +: 2] == 2'b01);
      if (in_q[2*i +: 2] == 2'b11) illegal = 1'b1;
    end
    conflict = ((greens & (greens - 4'd1)) != 4'd0) || (|greens && |yellows);
    case (in_q)
      8'h55:   dec = PH_RST;
      8'h80:   dec = PH_S0;
      8'h50:   dec = PH_S1;
      8'h20:   dec = PH_S2;
      8'h14:   dec = PH_S3;
      8'h08:   dec = PH_S4;
      8'h05:   dec = PH_S5;
      8'h02:   dec = PH_S6;
      8'h41:   dec = PH_S7;
      8'h00:   dec = PH_ALLRED;
      default: dec = PH_INVALID;
    endcase
  end

  // Phase state register. The state itself drives the phase output.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_NONE;
      change_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      change_q <= change;
    end
  end

  // Next phase follows the decode. Sequence and cycle events come from the
  // same step. Steps into or out of INVALID are already flagged elsewhere,
  // so they are not sequence faults.
  always_comb begin
    phase_d = phase_q;
    change  = 1'b0;
    seq_err = 1'b0;
    cyc_evt = 1'b0;
    if (dec != phase_q) begin
      phase_d = dec;
      change  = 1'b1;
      seq_err = (phase_q != PH_INVALID) && (dec != PH_INVALID) &&
                !seq_ok(phase_q, dec);
      cyc_evt = (phase_q == PH_S7) && (dec == PH_S0);
    end
  end

`ifdef PHASE_MON_DWELL_CHECK_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] presc_q;
  logic [4:0]    dwell_q, dwell_inc, dwell_exit;
  logic          wrap, is_green, is_yellow;
  int            lim_hi, lim_lo;

  // Dwell arithmetic. The exit value includes a second that completes on the
  // exit edge itself, so a phase held exactly N seconds exits with N.
  always_comb begin
    wrap       = (presc_q == PW'(TICK_DIV - 1));
    dwell_inc  = (dwell_q == 5'd31) ? 5'd31 : dwell_q + 5'd1;
    dwell_exit = wrap ? dwell_inc : dwell_q;
    is_green   = (phase_q == PH_S0) || (phase_q == PH_S2) ||
                 (phase_q == PH_S4) || (phase_q == PH_S6);
    is_yellow  = (phase_q == PH_S1) || (phase_q == PH_S3) ||
                 (phase_q == PH_S5) || (phase_q == PH_S7);
    lim_hi     = (is_green ? GREEN_SEC : YELLOW_SEC) + TOL_SEC;
    lim_lo     = (is_green ? GREEN_SEC : YELLOW_SEC) - TOL_SEC;
    dwell_err  = 1'b0;
    if (is_green || is_yellow) begin
      if (change)
        dwell_err = (int'(dwell_exit) < lim_lo) || (int'(dwell_exit) > lim_hi);
      else if (wrap)
        dwell_err = (int'(dwell_inc) > lim_hi);
    end
  end

  // Prescaler and seconds counter. Both are realigned on every phase change.
  always_ff @(posedge clk) begin
    if (reset || change) begin
      presc_q <= '0;
      dwell_q <= '0;
    end else if (wrap) begin
      presc_q <= '0;
      dwell_q <= dwell_inc;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign bus.dwell_sec = dwell_q;
`else
  assign dwell_err     = 1'b0;
  assign bus.dwell_sec = 5'd0;
`endif

  // Sticky faults and cycle count. An event on the same edge as clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q  <= '0;
      cycles_q <= '0;
    end else if (bus.clear) begin
      fault_q  <= {dwell_err, seq_err, illegal, conflict};
      cycles_q <= {7'd0, cyc_evt};
    end else begin
      fault_q  <= fault_q | {dwell_err, seq_err, illegal, conflict};
      cycles_q <= cycles_q + {7'd0, cyc_evt};
    end
  end

  assign bus.phase        = phase_q;
  assign bus.phase_change = change_q;
  assign bus.fault        = fault_q;
  assign bus.fault_any    = |fault_q;
  assign bus.cycles       = cycles_q;

endmodule

// File: tb/tb_traffic_phase_monitor.sv
// Testbench for traffic_phase_monitor with TICK_DIV=4, so one second is
// 4 clk cycles. Each driven pattern that should produce a new phase pushes
// that phase to exp_q, and every phase_change pulse pops and compares it.
// Status outputs are checked directly at chosen points.
module tb_traffic_phase_monitor;

`ifdef PHASE_MON_DWELL_CHECK_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [3:0] exp_q[$];
  logic [3:0] exp_ph;

  // Patterns for RST, S0..S7, packed as {north, east, south, west}.
  logic [7:0] pat [9] = '{8'h55, 8'h80, 8'h50, 8'h20, 8'h14,
                          8'h08, 8'h05, 8'h02, 8'h41};

  traffic_phase_monitor_if bus();

  traffic_phase_monitor #(
    .TICK_DIV  (4),
    .GREEN_SEC (5),
    .YELLOW_SEC(1),
    .TOL_SEC   (0)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Drive one pattern for ncyc cycles. If clr is set, clear is asserted on
  // the final cycle only.
  task automatic apply(input logic [7:0] codes, input int ncyc,
                       input logic [3:0] ph, input bit push, input bit clr);
    {bus.north, bus.east, bus.south, bus.west} = codes;
    if (push) exp_q.push_back(ph);
    for (int i = 0; i < ncyc; i++) begin
      bus.clear = clr && (i == ncyc - 1);
      @(negedge clk);
    end
    bus.clear = 1'b0;
  endtask

  // Scoreboard: each phase update must match the next expected phase.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.phase_change === 1'b1) begin
      check("phase_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_ph = exp_q.pop_front();
        check("phase_seq", 32'(bus.phase), 32'(exp_ph));
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.clear = 1'b0;
    {bus.north, bus.east, bus.south, bus.west} = pat[0];
    repeat (3) @(negedge clk);
    check("rst_phase",    32'(bus.phase), 32'hE);
    check("rst_pchg",     32'(bus.phase_change), 32'd0);
    check("rst_dwell",    32'(bus.dwell_sec), 32'd0);
    check("rst_fault",    32'(bus.fault), 32'd0);
    check("rst_faultany", 32'(bus.fault_any), 32'd0);
    check("rst_cycles",   32'(bus.cycles), 32'd0);

    // Nominal: RST, two full cycles at controller timing, then S0.
    reset = 1'b0;
    apply(pat[0], 4, 4'h0, 1, 0);
    for (int c = 0; c < 2; c++)
      for (int p = 1; p <= 8; p++)
        apply(pat[p], (p % 2 == 1) ? 20 : 4, 4'(p), 1, 0);
    apply(pat[1], 20, 4'h1, 1, 0);
    check("nom_cycles", 32'(bus.cycles), 32'd2);
    check("nom_fault",  32'(bus.fault), 32'd0);
    check("nom_phase",  32'(bus.phase), 32'h1);
    check("nom_dwell",  32'(bus.dwell_sec), DWELL_EN ? 32'd4 : 32'd0);

    // Conflict: N=G and E=G for one cycle during S0.
    apply(8'hA0, 1, 4'hF, 1, 0);
    apply(pat[1], 1, 4'h1, 1, 0);
    check("conf_phase", 32'(bus.phase), 32'hF);
    check("conf_fault", 32'(bus.fault), 32'h1);
    check("conf_any",   32'(bus.fault_any), 32'd1);
    apply(pat[1], 1, 4'h1, 0, 1);
    check("clr_fault",  32'(bus.fault), 32'd0);
    check("clr_cycles", 32'(bus.cycles), 32'd0);
    apply(pat[1], 18, 4'h1, 0, 0);
    apply(pat[2], 4, 4'h2, 1, 0);

    // Illegal code on west, then clear while it is still present.
    apply(8'h03, 2, 4'hF, 1, 0);
    check("ill_fault", 32'(bus.fault), 32'h2);
    check("ill_phase", 32'(bus.phase), 32'hF);
    apply(8'h03, 1, 4'hF, 0, 1);
    check("ill_clr_hold", 32'(bus.fault), 32'h2);
    apply(8'h00, 4, 4'h9, 1, 1);
    check("allred_clr", 32'(bus.fault), 32'd0);
    apply(pat[0], 4, 4'h0, 1, 0);
    apply(pat[1], 20, 4'h1, 1, 0);
    check("allred_rst_ok", 32'(bus.fault), 32'd0);

    // Sequence fault: S0 directly to S2.
    apply(pat[3], 4, 4'h3, 1, 0);
    check("seq_phase", 32'(bus.phase), 32'h3);
    check("seq_fault", 32'(bus.fault), 32'h4);
    apply(pat[4], 4, 4'h4, 1, 1);
    check("seq_clr", 32'(bus.fault), 32'd0);

    // Understay: S0 held 3 s.
    apply(pat[5], 20, 4'h5, 1, 0);
    apply(pat[6], 4, 4'h6, 1, 0);
    apply(pat[7], 20, 4'h7, 1, 0);
    apply(pat[8], 4, 4'h8, 1, 0);
    apply(pat[1], 12, 4'h1, 1, 0);
    apply(pat[2], 2, 4'h2, 1, 0);
    check("under_fault", 32'(bus.fault), DWELL_EN ? 32'h8 : 32'h0);
    check("under_cycles", 32'(bus.cycles), 32'd1);

    // Overstay: S1 flagged on the edge where dwell_sec reaches 2.
    apply(pat[2], 1, 4'h2, 0, 1);
    check("over_clr", 32'(bus.fault), 32'd0);
    apply(pat[2], 6, 4'h2, 0, 0);
    check("over_pre_dwell", 32'(bus.dwell_sec), DWELL_EN ? 32'd1 : 32'd0);
    check("over_pre_fault", 32'(bus.fault), 32'd0);
    apply(pat[2], 1, 4'h2, 0, 0);
    check("over_dwell", 32'(bus.dwell_sec), DWELL_EN ? 32'd2 : 32'd0);
    check("over_fault", 32'(bus.fault), DWELL_EN ? 32'h8 : 32'h0);

    // Reset in S4 with faults pending.
    apply(pat[3], 20, 4'h3, 1, 0);
    apply(pat[4], 4, 4'h4, 1, 0);
    apply(pat[5], 4, 4'h5, 1, 0);
    apply(8'h0B, 1, 4'hF, 1, 0);
    apply(pat[5], 4, 4'h5, 1, 0);
    check("s4_ill", 32'(bus.fault[1]), 32'd1);
    check("s4_any", 32'(bus.fault_any), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_phase",  32'(bus.phase), 32'hE);
    check("mid_rst_pchg",   32'(bus.phase_change), 32'd0);
    check("mid_rst_dwell",  32'(bus.dwell_sec), 32'd0);
    check("mid_rst_fault",  32'(bus.fault), 32'd0);
    check("mid_rst_any",    32'(bus.fault_any), 32'd0);
    check("mid_rst_cycles", 32'(bus.cycles), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply(pat[5], 3, 4'h5, 1, 0);
    check("post_rst_phase", 32'(bus.phase), 32'h5);
    check("post_rst_fault", 32'(bus.fault), 32'd0);
    check("post_rst_pchg",  32'(bus.phase_change), 32'd0);

    repeat (2) @(negedge clk);
    check("phase_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
